// File: rtl/multi_seg_scan.sv
// Time-multiplexed seven-segment driver: scans DIGITS hex digits with 16-level PWM,
// leading-zero blanking, per-digit decimal points and a tear-free per-frame snapshot.
module multi_seg_scan #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SUB_DIV        = 3125,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [4*DIGITS-1:0]       num_i,
  input  logic [DIGITS-1:0]         dp_in_i,
  input  logic                      blank_lz_i,
  input  logic [3:0]                bright_i,
  output logic [DIGITS-1:0]         digit_sel_o,
  output logic [7:0]                seg_out_o,
  output logic [$clog2(DIGITS)-1:0] scan_idx_o
);

  localparam int unsigned IdxW   = $clog2(DIGITS);
  localparam int unsigned PrescW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(DIGITS - 1);
  localparam logic [PrescW-1:0] LastPresc = PrescW'(SUB_DIV - 1);
  localparam logic [7:0]        SegOff    = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DigOff    = {DIGITS{DIG_ACTIVE_LOW}};

  logic [PrescW-1:0]   presc_q, presc_d;
  logic [3:0]          phase_q, phase_d;
  logic [IdxW-1:0]     scan_q, scan_d;
  logic                en_q;
  logic [4*DIGITS-1:0] num_q;
  logic [DIGITS-1:0]   dp_q;
  logic                blz_q;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic [7:0]          seg_q, seg_d;

  logic                sub_tick, slot_end, en_rise, snap, lit, all_zero;
  logic [4*DIGITS-1:0] src_num;
  logic [DIGITS-1:0]   src_dp, blank_vec, onehot;
  logic                src_blz;
  logic [3:0]          nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign sub_tick = (presc_q == LastPresc);
  assign slot_end = sub_tick && (phase_q == 4'hF);
  assign en_rise  = en_i && !en_q;
  assign snap     = en_rise || (en_i && slot_end && (scan_q == LastIdx));

  always_comb begin
    presc_d = '0;
    phase_d = '0;
    scan_d  = '0;
    if (en_i) begin
      presc_d = sub_tick ? '0 : presc_q + 1'b1;
      phase_d = sub_tick ? phase_q + 4'd1 : phase_q;
      scan_d  = scan_q;
      if (slot_end) begin
        scan_d = (scan_q == LastIdx) ? '0 : scan_q + 1'b1;
      end
    end
  end

  // On the enable-rise cycle the frame registers are still loading, so decode the live inputs.
  assign src_num = en_rise ? num_i      : num_q;
  assign src_dp  = en_rise ? dp_in_i    : dp_q;
  assign src_blz = en_rise ? blank_lz_i : blz_q;
  assign nibble  = src_num[{scan_q, 2'b00} +: 4];

  always_comb begin
    all_zero  = 1'b1;
    blank_vec = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero     = all_zero && (src_num[4*k +: 4] == 4'h0);
      blank_vec[k] = src_blz && all_zero;
    end
  end

  always_comb begin
    onehot         = '0;
    onehot[scan_q] = 1'b1;
    lit   = en_i && !blank_vec[scan_q] && ((bright_i == 4'hF) || (phase_q < bright_i));
    dig_d = lit ? (onehot ^ DigOff) : DigOff;
    seg_d = lit ? ({src_dp[scan_q], hex7(nibble)} ^ SegOff) : SegOff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      phase_q <= '0;
      scan_q  <= '0;
      en_q    <= 1'b0;
      num_q   <= '0;
      dp_q    <= '0;
      blz_q   <= 1'b0;
      dig_q   <= DigOff;
      seg_q   <= SegOff;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      scan_q  <= scan_d;
      en_q    <= en_i;
      if (snap) begin
        num_q <= num_i;
        dp_q  <= dp_in_i;
        blz_q <= blank_lz_i;
      end
      dig_q   <= dig_d;
      seg_q   <= seg_d;
    end
  end

  assign digit_sel_o = dig_q;
  assign seg_out_o   = seg_q;
  assign scan_idx_o  = scan_q;

endmodule

// File: tb/tb_multi_seg_scan.sv
// Directed bench for multi_seg_scan with DIGITS=4, SUB_DIV=4 (64-cycle slots, 256-cycle frames).
module tb_multi_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] num = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  bright = '0;
  logic [3:0]  digit_sel;
  logic [7:0]  seg_out;
  logic [1:0]  scan_idx;

  int checks = 0;
  int failures = 0;

  logic [3:0] exp_dig [4];
  logic [7:0] exp_seg [4];
  int         hit [4];
  int         lit [4];
  int         dark [4];
  int         multi;
  logic [1:0] idx_log [256];

  always #5 clk = ~clk;

  multi_seg_scan #(
    .DIGITS(4),
    .SUB_DIV(4),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .num_i      (num),
    .dp_in_i    (dp_in),
    .blank_lz_i (blank_lz),
    .bright_i   (bright),
    .digit_sel_o(digit_sel),
    .seg_out_o  (seg_out),
    .scan_idx_o (scan_idx)
  );

  // After this returns, the next posedge is the first clocked cycle out of reset.
  task automatic restart(input logic [15:0] n, input logic [3:0] dp, input logic blz,
                         input logic [3:0] br);
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1;
    num = n;
    dp_in = dp;
    blank_lz = blz;
    bright = br;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Capture one full frame; sample k reflects the state before posedge k.
  task automatic run_frame(input logic [15:0] n, input logic [3:0] dp, input logic blz,
                           input logic [3:0] br);
    restart(n, dp, blz, br);
    multi = 0;
    for (int s = 0; s < 4; s++) begin
      hit[s] = 0;
      lit[s] = 0;
      dark[s] = 0;
    end
    for (int k = 0; k < 256; k++) begin
      int s;
      @(negedge clk);
      s = k / 64;
      idx_log[k] = scan_idx;
      if (digit_sel == exp_dig[s] && seg_out == exp_seg[s]) hit[s]++;
      if (digit_sel != 4'hF) lit[s]++;
      if (digit_sel == 4'hF && seg_out == 8'hFF) dark[s]++;
      if ($countones(~digit_sel) > 1) multi++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    num = 16'h1234;
    bright = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if (digit_sel !== 4'hF) begin
      failures++;
      $display("FAIL reset_digit_sel: got %h expected F", digit_sel);
    end
    checks++;
    if (seg_out !== 8'hFF) begin
      failures++;
      $display("FAIL reset_seg_out: got %h expected FF", seg_out);
    end
    checks++;
    if (scan_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_scan_idx: got %0d expected 0", scan_idx);
    end
  endtask

  task automatic test_scan();
    exp_dig = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};  // '4','3','2','1'
    run_frame(16'h1234, 4'b0000, 1'b0, 4'hF);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (hit[s] != 64) begin
        failures++;
        $display("FAIL scan_slot%0d: got %0d matching cycles expected 64", s, hit[s]);
      end
    end
    checks++;
    if (idx_log[62] !== 2'd0 || idx_log[63] !== 2'd1) begin
      failures++;
      $display("FAIL scan_idx_step: got %0d,%0d expected 0,1", idx_log[62], idx_log[63]);
    end
    checks++;
    if (idx_log[254] !== 2'd3 || idx_log[255] !== 2'd0) begin
      failures++;
      $display("FAIL scan_idx_wrap: got %0d,%0d expected 3,0", idx_log[254], idx_log[255]);
    end
    checks++;
    if (multi != 0) begin
      failures++;
      $display("FAIL scan_onehot: got %0d multi-select cycles expected 0", multi);
    end
  endtask

  task automatic test_blank();
    exp_dig = '{4'hE, 4'hD, 4'hF, 4'hF};
    exp_seg = '{8'hC0, 8'hF8, 8'hFF, 8'hFF};  // '0','7',dark,dark (dp on digit 3 suppressed)
    run_frame(16'h0070, 4'b1000, 1'b1, 4'hF);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (hit[s] != 64) begin
        failures++;
        $display("FAIL blank_slot%0d: got %0d matching cycles expected 64", s, hit[s]);
      end
    end
  endtask

  task automatic test_dp_no_blank();
    exp_dig = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_seg = '{8'h40, 8'hF8, 8'hC0, 8'hC0};  // '0.' then '7','0','0'
    run_frame(16'h0070, 4'b0001, 1'b0, 4'hF);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (hit[s] != 64) begin
        failures++;
        $display("FAIL dp_slot%0d: got %0d matching cycles expected 64", s, hit[s]);
      end
    end
  endtask

  task automatic test_pwm();
    exp_dig = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    run_frame(16'h1234, 4'b0000, 1'b0, 4'd4);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (hit[s] != 16 || dark[s] != 48) begin
        failures++;
        $display("FAIL pwm4_slot%0d: got lit=%0d dark=%0d expected lit=16 dark=48",
                 s, hit[s], dark[s]);
      end
    end
    run_frame(16'h1234, 4'b0000, 1'b0, 4'd14);
    checks++;
    if (hit[2] != 56 || dark[2] != 8) begin
      failures++;
      $display("FAIL pwm14_slot2: got lit=%0d dark=%0d expected lit=56 dark=8", hit[2], dark[2]);
    end
    run_frame(16'h1234, 4'b0000, 1'b0, 4'd0);
    checks++;
    if (lit[0] + lit[1] + lit[2] + lit[3] != 0 || dark[0] + dark[1] + dark[2] + dark[3] != 256)
    begin
      failures++;
      $display("FAIL pwm0_dark: got lit=%0d expected 0", lit[0] + lit[1] + lit[2] + lit[3]);
    end
  endtask

  task automatic test_snapshot();
    int old_ok;
    int new_ok;
    old_ok = 0;
    new_ok = 0;
    restart(16'h1111, 4'b0000, 1'b0, 4'hF);
    for (int k = 0; k < 512; k++) begin
      logic [3:0] ed;
      logic [7:0] es;
      @(negedge clk);
      ed = ~(4'b0001 << ((k / 64) % 4));
      es = (k < 256) ? 8'hF9 : 8'hA4;
      if (digit_sel == ed && seg_out == es) begin
        if (k < 256) old_ok++;
        else new_ok++;
      end
      if (k == 100) num = 16'h2222;
    end
    checks++;
    if (old_ok != 256) begin
      failures++;
      $display("FAIL snapshot_old_frame: got %0d cycles of '1' expected 256", old_ok);
    end
    checks++;
    if (new_ok != 256) begin
      failures++;
      $display("FAIL snapshot_new_frame: got %0d cycles of '2' expected 256", new_ok);
    end
  endtask

  task automatic test_enable();
    int dark_cnt;
    dark_cnt = 0;
    restart(16'h1234, 4'b0000, 1'b0, 4'hF);
    repeat (141) @(negedge clk);
    checks++;
    if (scan_idx !== 2'd2 || digit_sel !== 4'hB) begin
      failures++;
      $display("FAIL en_pre_drop: got idx=%0d sel=%h expected idx=2 sel=B", scan_idx, digit_sel);
    end
    en = 1'b0;
    num = 16'h5678;
    @(negedge clk);
    checks++;
    if (digit_sel !== 4'hF || seg_out !== 8'hFF || scan_idx !== 2'd0) begin
      failures++;
      $display("FAIL en_drop: got sel=%h seg=%h idx=%0d expected F FF 0",
               digit_sel, seg_out, scan_idx);
    end
    repeat (4) begin
      @(negedge clk);
      if (digit_sel == 4'hF && seg_out == 8'hFF) dark_cnt++;
    end
    checks++;
    if (dark_cnt != 4) begin
      failures++;
      $display("FAIL en_low_dark: got %0d dark cycles expected 4", dark_cnt);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (digit_sel !== 4'hE || seg_out !== 8'h80 || scan_idx !== 2'd0) begin
      failures++;
      $display("FAIL en_rise_first: got sel=%h seg=%h idx=%0d expected E 80 0",
               digit_sel, seg_out, scan_idx);
    end
    repeat (63) @(negedge clk);
    checks++;
    if (digit_sel !== 4'hE) begin
      failures++;
      $display("FAIL en_slot0_end: got sel=%h expected E", digit_sel);
    end
    @(negedge clk);
    checks++;
    if (digit_sel !== 4'hD || seg_out !== 8'hF8 || scan_idx !== 2'd1) begin
      failures++;
      $display("FAIL en_slot1_start: got sel=%h seg=%h idx=%0d expected D F8 1",
               digit_sel, seg_out, scan_idx);
    end
  endtask

  task automatic test_reset_mid();
    restart(16'h1234, 4'b0000, 1'b0, 4'hF);
    repeat (81) @(negedge clk);
    checks++;
    if (scan_idx !== 2'd1 || digit_sel !== 4'hD) begin
      failures++;
      $display("FAIL rst_mid_pre: got idx=%0d sel=%h expected 1 D", scan_idx, digit_sel);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (digit_sel !== 4'hF || seg_out !== 8'hFF || scan_idx !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid_async: got sel=%h seg=%h idx=%0d expected F FF 0",
               digit_sel, seg_out, scan_idx);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_dp_no_blank();
    test_pwm();
    test_snapshot();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
